// File: rtl/mau_pkg.sv
// mau_pkg: shared types and helpers for the memory access unit.
//   mem_op_t    : 4-bit memory op code from execute
//   exc_t       : 2-bit exception code returned to writeback
//   mau_state_t : control FSM states
//   SIZE_*      : dreq_size encodings (log2 of access bytes)
package mau_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_LWU  = 4'd6,
        OP_LD   = 4'd7,
        OP_SB   = 4'd8,
        OP_SH   = 4'd9,
        OP_SW   = 4'd10,
        OP_SD   = 4'd11
    } mem_op_t;

    typedef enum logic [1:0] {
        EXC_NONE = 2'd0,
        EXC_ADEL = 2'd1,
        EXC_ADES = 2'd2
    } exc_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } mau_state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    function automatic logic [1:0] op_size(input mem_op_t op);
        logic [1:0] size_v;
        case (op)
            OP_LB, OP_LBU, OP_SB: size_v = SIZE_B;
            OP_LH, OP_LHU, OP_SH: size_v = SIZE_H;
            OP_LW, OP_LWU, OP_SW: size_v = SIZE_W;
            OP_LD, OP_SD:         size_v = SIZE_D;
            default:              size_v = SIZE_B;
        endcase
        return size_v;
    endfunction

    function automatic logic op_is_load(input mem_op_t op);
        logic is_v;
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWU, OP_LD: is_v = 1'b1;
            default:                                            is_v = 1'b0;
        endcase
        return is_v;
    endfunction

    function automatic logic op_is_store(input mem_op_t op);
        logic is_v;
        case (op)
            OP_SB, OP_SH, OP_SW, OP_SD: is_v = 1'b1;
            default:                    is_v = 1'b0;
        endcase
        return is_v;
    endfunction

    function automatic logic op_is_signed(input mem_op_t op);
        logic is_v;
        case (op)
            OP_LB, OP_LH, OP_LW: is_v = 1'b1;
            default:             is_v = 1'b0;
        endcase
        return is_v;
    endfunction

endpackage

// File: rtl/mau_load_align.sv
// mau_load_align: combinational load lane extraction and extension.
//   data     : raw bus read data (DATA_W)
//   offset   : byte offset of the access within the bus word
//   size     : access size (SIZE_B/H/W/D)
//   sign_ext : 1 = sign-extend, 0 = zero-extend
//   result   : extracted value extended to DATA_W
module mau_load_align
    import mau_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]             data,
    input  logic [$clog2(DATA_W/8)-1:0]   offset,
    input  logic [1:0]                    size,
    input  logic                          sign_ext,
    output logic [DATA_W-1:0]             result
);

    logic [DATA_W-1:0] shifted_s;

    // Move the addressed lane to bit 0, then extend from the access width.
    always_comb begin
        shifted_s = data >> {offset, 3'b000};
        case (size)
            SIZE_B: result = sign_ext ? DATA_W'(signed'(shifted_s[7:0]))
                                      : DATA_W'(shifted_s[7:0]);
            SIZE_H: result = sign_ext ? DATA_W'(signed'(shifted_s[15:0]))
                                      : DATA_W'(shifted_s[15:0]);
            SIZE_W: result = sign_ext ? DATA_W'(signed'(shifted_s[31:0]))
                                      : DATA_W'(shifted_s[31:0]);
            default: result = shifted_s;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: handshaked memory stage between execute and writeback.
//   in_valid/in_ready, in_op, in_val, in_wdata : op from execute
//   flush                                      : kill the op held in the unit
//   out_valid/out_ready, out_result, out_exc,
//   out_badvaddr                               : result to writeback
//   dreq_valid, dreq_addr, dreq_size,
//   dreq_strobe, dreq_data                     : bus request
//   dresp_addr_ok, dresp_data_ok, dresp_data   : bus response
// Build option MAU_MISALIGN_CHECK_EN: when defined, misaligned accesses
// raise ADEL/ADES without touching the bus; when undefined, the low
// address bits are masked to the access size and the access proceeds.
// Exception results carry out_result = 0; load requests drive dreq_data = 0.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_op,
    input  logic [DATA_W-1:0]     in_val,
    input  logic [DATA_W-1:0]     in_wdata,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_result,
    output logic [1:0]            out_exc,
    output logic [ADDR_W-1:0]     out_badvaddr,
    output logic                  dreq_valid,
    output logic [ADDR_W-1:0]     dreq_addr,
    output logic [1:0]            dreq_size,
    output logic [DATA_W/8-1:0]   dreq_strobe,
    output logic [DATA_W-1:0]     dreq_data,
    input  logic                  dresp_addr_ok,
    input  logic                  dresp_data_ok,
    input  logic [DATA_W-1:0]     dresp_data
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    // Ops that do not exist on a 32-bit datapath degrade to pass-through.
    function automatic mem_op_t legal_op(input logic [3:0] raw);
        mem_op_t op_v;
        if (raw > 4'd11) begin
            op_v = OP_NONE;
        end else begin
            op_v = mem_op_t'(raw);
        end
        if ((DATA_W == 32) && ((op_v == OP_LWU) || (op_v == OP_LD) || (op_v == OP_SD))) begin
            op_v = OP_NONE;
        end
        return op_v;
    endfunction

    mem_op_t            op_s;
    logic [1:0]         size_s;
    logic [7:0]         byte_mask_s;
    logic [ADDR_W-1:0]  addr_raw_s;
    logic [ADDR_W-1:0]  low_mask_s;
    logic [ADDR_W-1:0]  addr_eff_s;
    logic               misalign_s;
    exc_t               exc_s;
    logic [STRB_W-1:0]  strobe_s;
    logic [DATA_W-1:0]  wdata_rep_s;
    logic [DATA_W-1:0]  load_data_s;
    logic [DATA_W-1:0]  result_s;

    mau_state_t         state_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [DATA_W-1:0]  out_result_r;
    exc_t               out_exc_r;
    logic [ADDR_W-1:0]  out_badvaddr_r;
    logic               dreq_valid_r;
    logic [ADDR_W-1:0]  dreq_addr_r;
    logic [1:0]         dreq_size_r;
    logic [STRB_W-1:0]  dreq_strobe_r;
    logic [DATA_W-1:0]  dreq_data_r;
    logic [DATA_W-1:0]  val_r;
    logic               load_r;
    logic               sign_r;
    logic               flush_pend_r;

    // Decode the incoming op: size, alignment, exception, strobe and lane data.
    always_comb begin
        op_s       = legal_op(in_op);
        size_s     = op_size(op_s);
        addr_raw_s = ADDR_W'(in_val);
        case (size_s)
            SIZE_B: begin
                byte_mask_s = 8'h01;
                low_mask_s  = ADDR_W'(3'd0);
            end
            SIZE_H: begin
                byte_mask_s = 8'h03;
                low_mask_s  = ADDR_W'(3'd1);
            end
            SIZE_W: begin
                byte_mask_s = 8'h0F;
                low_mask_s  = ADDR_W'(3'd3);
            end
            default: begin
                byte_mask_s = 8'hFF;
                low_mask_s  = ADDR_W'(3'd7);
            end
        endcase
`ifdef MAU_MISALIGN_CHECK_EN
        misalign_s = (addr_raw_s & low_mask_s) != {ADDR_W{1'b0}};
        addr_eff_s = addr_raw_s;
`else
        misalign_s = 1'b0;
        addr_eff_s = addr_raw_s & ~low_mask_s;
`endif
        if (!misalign_s) begin
            exc_s = EXC_NONE;
        end else if (op_is_store(op_s)) begin
            exc_s = EXC_ADES;
        end else begin
            exc_s = EXC_ADEL;
        end
        strobe_s    = {STRB_W{1'b0}};
        wdata_rep_s = {DATA_W{1'b0}};
        if (op_is_store(op_s)) begin
            strobe_s = STRB_W'(byte_mask_s) << addr_eff_s[OFF_W-1:0];
            // Replicate the low byte/half/word so every lane carries it.
            for (int i = 0; i < STRB_W; i++) begin
                case (size_s)
                    SIZE_B:  wdata_rep_s[i*8 +: 8] = in_wdata[7:0];
                    SIZE_H:  wdata_rep_s[i*8 +: 8] = in_wdata[(i%2)*8 +: 8];
                    SIZE_W:  wdata_rep_s[i*8 +: 8] = in_wdata[(i%4)*8 +: 8];
                    default: wdata_rep_s[i*8 +: 8] = in_wdata[i*8 +: 8];
                endcase
            end
        end else begin
            strobe_s    = {STRB_W{1'b0}};
            wdata_rep_s = {DATA_W{1'b0}};
        end
    end

    mau_load_align #(
        .DATA_W   (DATA_W)
    ) u_load_align (
        .data     (dresp_data),
        .offset   (dreq_addr_r[OFF_W-1:0]),
        .size     (dreq_size_r),
        .sign_ext (sign_r),
        .result   (load_data_s)
    );

    // Value presented to writeback when the bus completes.
    always_comb begin
        if (load_r) begin
            result_s = load_data_s;
        end else begin
            result_s = val_r;
        end
    end

    // Control FSM and all registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r        <= ST_IDLE;
            in_ready_r     <= 1'b1;
            out_valid_r    <= 1'b0;
            out_result_r   <= {DATA_W{1'b0}};
            out_exc_r      <= EXC_NONE;
            out_badvaddr_r <= {ADDR_W{1'b0}};
            dreq_valid_r   <= 1'b0;
            dreq_addr_r    <= {ADDR_W{1'b0}};
            dreq_size_r    <= 2'd0;
            dreq_strobe_r  <= {STRB_W{1'b0}};
            dreq_data_r    <= {DATA_W{1'b0}};
            val_r          <= {DATA_W{1'b0}};
            load_r         <= 1'b0;
            sign_r         <= 1'b0;
            flush_pend_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // A flush in IDLE has nothing to kill and blocks acceptance.
                    if (in_valid && !flush) begin
                        in_ready_r   <= 1'b0;
                        val_r        <= in_val;
                        load_r       <= op_is_load(op_s);
                        sign_r       <= op_is_signed(op_s);
                        flush_pend_r <= 1'b0;
                        if ((op_s == OP_NONE) || misalign_s) begin
                            state_r        <= ST_DONE;
                            out_valid_r    <= 1'b1;
                            out_result_r   <= misalign_s ? {DATA_W{1'b0}} : in_val;
                            out_exc_r      <= exc_s;
                            out_badvaddr_r <= misalign_s ? addr_raw_s : {ADDR_W{1'b0}};
                        end else begin
                            state_r       <= ST_REQ;
                            dreq_valid_r  <= 1'b1;
                            dreq_addr_r   <= addr_eff_s;
                            dreq_size_r   <= size_s;
                            dreq_strobe_r <= strobe_s;
                            dreq_data_r   <= wdata_rep_s;
                        end
                    end
                end
                ST_REQ: begin
                    // The request cannot be withdrawn; a flush is remembered
                    // until the bus accepts it.
                    if (dresp_addr_ok) begin
                        dreq_valid_r <= 1'b0;
                        if (dresp_data_ok) begin
                            if (flush || flush_pend_r) begin
                                state_r    <= ST_IDLE;
                                in_ready_r <= 1'b1;
                            end else begin
                                state_r        <= ST_DONE;
                                out_valid_r    <= 1'b1;
                                out_result_r   <= result_s;
                                out_exc_r      <= EXC_NONE;
                                out_badvaddr_r <= {ADDR_W{1'b0}};
                            end
                        end else if (flush || flush_pend_r) begin
                            state_r <= ST_DRAIN;
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end else if (flush) begin
                        flush_pend_r <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (dresp_data_ok) begin
                        if (flush) begin
                            state_r    <= ST_IDLE;
                            in_ready_r <= 1'b1;
                        end else begin
                            state_r        <= ST_DONE;
                            out_valid_r    <= 1'b1;
                            out_result_r   <= result_s;
                            out_exc_r      <= EXC_NONE;
                            out_badvaddr_r <= {ADDR_W{1'b0}};
                        end
                    end else if (flush) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    if (flush || out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Swallow the response of the killed access.
                    if (dresp_data_ok) begin
                        state_r      <= ST_IDLE;
                        in_ready_r   <= 1'b1;
                        flush_pend_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    in_ready_r   <= 1'b1;
                    out_valid_r  <= 1'b0;
                    dreq_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_r;
    assign out_valid    = out_valid_r;
    assign out_result   = out_result_r;
    assign out_exc      = out_exc_r;
    assign out_badvaddr = out_badvaddr_r;
    assign dreq_valid   = dreq_valid_r;
    assign dreq_addr    = dreq_addr_r;
    assign dreq_size    = dreq_size_r;
    assign dreq_strobe  = dreq_strobe_r;
    assign dreq_data    = dreq_data_r;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory-stage engine for the pipelined MIPS core. It replaces the single-cycle memory stage register with a handshaked unit. The unit accepts one load/store/pass-through op from execute and drives the data bus through a request/address-ok/data-ok handshake. It detects misaligned addresses, sign- or zero-extends loads, generates store strobes, and returns the result to writeback. Supports DATA_W of 32 or 64 bits and upstream flush during an outstanding access.

## Interface
- DATA_W, 32: datapath and bus width; 32 or 64 (64 enables LD/SD/LWU).
- ADDR_W, 32: address width.
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- in_valid / in_ready  in/out  1  op handshake from execute.
- in_op  in  4  mem_op_t: NONE, LB, LBU, LH, LHU, LW, LWU, LD, SB, SH, SW, SD.
- in_val  in  DATA_W  ALU result; this is the address for memory ops and the result for NONE.
- in_wdata  in  DATA_W  store data.
- flush  in  1  kill the op held in the unit.
- out_valid / out_ready  out/in  1  result handshake to writeback.
- out_result  out  DATA_W  load data or passthrough value.
- out_exc  out  2  exc_t: NONE, ADEL, ADES.
- out_badvaddr  out  ADDR_W  faulting address; 0 when out_exc=NONE.
- dreq_valid  out  1  bus request.
- dreq_addr  out  ADDR_W  bus address.
- dreq_size  out  2  size of access: 0=1B, 1=2B, 2=4B, 3=8B.
- dreq_strobe  out  DATA_W/8  byte write enables; all 0 for loads.
- dreq_data  out  DATA_W  store data replicated across lanes.
- dresp_addr_ok  in  1  bus accepted the request.
- dresp_data_ok  in  1  bus returned data or completed the write.
- dresp_data  in  DATA_W  bus read data.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN. in_ready=1 only in IDLE.
- IDLE, in_valid:
  - Latch op, address, wdata.
  - Go to DONE for NONE or for a misaligned op (no bus request).
  - Go to REQ otherwise.
- Alignment rules: H needs addr[0]=0; W needs addr[1:0]=0; D needs addr[2:0]=0.
- Misaligned load gives ADEL; misaligned store gives ADES. out_badvaddr = address.
- REQ:
  - dreq_valid=1. Address, size, strobe and data stay stable until addr_ok.
  - addr_ok alone: go to WAIT.
  - addr_ok and data_ok in the same cycle: go to DONE.
- WAIT, data_ok: capture the extracted load data and go to DONE. Stores capture in_val.
- DONE: out_valid=1 and hold until out_ready, then go to IDLE.
- Lane select: byte offset = addr[log2(DATA_W/8)-1:0].
  - Load extraction picks the addressed lane and extends to DATA_W: LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend.
- Store strobes: offset-shifted mask of 1, 2, 4 or 8 ones. SB/SH/SW replicate the low byte, half or word across the bus.
- Flush behaviour:
  - In IDLE or DONE: go to IDLE; out_valid drops next cycle.
  - In REQ: the request is never retracted. Go to DRAIN once addr_ok arrives (to IDLE if data_ok arrives in the same cycle).
  - In WAIT: go to DRAIN.
  - DRAIN: wait for data_ok, discard the data, go to IDLE. No out_valid is issued.
- Ops not legal at DATA_W=32 (LD/SD/LWU) are treated as NONE.

## Timing
- Reset values: state IDLE; in_ready=1; out_valid=0, dreq_valid=0; all data, strobe and exc outputs 0.
- Reset mid-access abandons the access immediately. The bus is reset in the same domain.
- Latency, accept edge to out_valid:
  - 1 cycle for NONE or misaligned.
  - 2 cycles when addr_ok and data_ok are both same-cycle.
  - Otherwise 2 + addr wait + data wait.
- Throughput: one op per 2 cycles at best. Acceptance is never overlapped with DONE.
- out_* stay stable while out_valid=1 and out_ready=0.

## Configuration
- MAU_MISALIGN_CHECK_EN:
  - Defined: the alignment checks above apply.
  - Undefined: no ADEL/ADES. The low address bits are masked to the access size and the access proceeds. out_exc stays NONE.

## Structure
- mau_pkg holds mem_op_t, exc_t, mau_state_t, and the size encodings.
- Sub-module mau_load_align: combinational lane extraction plus sign/zero extension, parametrised by DATA_W. It is instanced once and unit-tested separately.

## Test plan
- DATA_W=32, LB at 0x1003, bus returns 0x80FF_FF00 → out_result 0xFFFF_FF80, dreq_strobe 0000, dreq_size 0.
- SH at 0x2002 with wdata 0x1234_ABCD → dreq_strobe 1100, dreq_data 0xABCD_ABCD, out_exc NONE.
- LW at 0x3001 (macro defined) → no dreq_valid, out_exc ADEL, out_badvaddr 0x3001, out_valid 1 cycle after accept.
- addr_ok held low 3 cycles, then data_ok 2 cycles later → request fields stable throughout, out_valid 7 cycles after accept.
- flush in REQ before addr_ok → dreq_valid held until addr_ok, data_ok discarded, no out_valid, in_ready high after data_ok.
- DATA_W=64, LWU at 0x4004, bus data 0x8765_4321_0000_0000 → out_result 0x0000_0000_8765_4321.
